// File: rtl/led_panel_mmio.sv
// led_panel_mmio: CPU6 memory-mapped 8-bit LED panel with set/clear/toggle aliases.
// Define LEDPANEL_BLINK_EN to build the hardware blink engine (BMASK/BRATE/STATUS).
module led_panel_mmio #(
    parameter logic [18:0] BASE_ADDR  = 19'h0F100,
    parameter int          ACTIVE_LOW = 1,
    parameter int unsigned PRESCALE   = 65536
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [18:0] address,
    input  logic        write_en,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        sel,
    output logic [7:0]  leds
);

    localparam logic [2:0] OFF_LED    = 3'd0;
    localparam logic [2:0] OFF_SET    = 3'd1;
    localparam logic [2:0] OFF_CLR    = 3'd2;
    localparam logic [2:0] OFF_TGL    = 3'd3;
    localparam logic [2:0] OFF_BMASK  = 3'd4;
    localparam logic [2:0] OFF_BRATE  = 3'd5;
    localparam logic [2:0] OFF_STATUS = 3'd6;
    localparam logic [2:0] OFF_ID     = 3'd7;

    localparam logic [7:0] ID_VALUE  = 8'h4C;
    localparam logic [7:0] LEDS_IDLE = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [2:0] offset;
    logic       wr;
    logic [7:0] led_r;
    logic [7:0] led_next;
    logic [7:0] lit;
    logic [7:0] bm_rd;
    logic [7:0] br_rd;
    logic [7:0] status_rd;

    assign offset = address[2:0];
    assign sel    = (address[18:3] == BASE_ADDR[18:3]);
    assign wr     = write_en & sel;

    always_comb begin
        led_next = led_r;
        if (wr) begin
            case (offset)
                OFF_LED: led_next = data_in;
                OFF_SET: led_next = led_r | data_in;
                OFF_CLR: led_next = led_r & ~data_in;
                OFF_TGL: led_next = led_r ^ data_in;
                default: led_next = led_r;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            led_r <= 8'h00;
        end else begin
            led_r <= led_next;
        end
    end

`ifdef LEDPANEL_BLINK_EN
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc;
    logic          tick;
    logic [7:0]    rcnt;
    logic [7:0]    bm_r;
    logic [7:0]    br_r;
    logic          phase;
    logic          br_wr;

    assign tick  = (presc == PRE_LAST);
    assign br_wr = wr && (offset == OFF_BRATE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bm_r <= 8'h00;
        end else if (wr && (offset == OFF_BMASK)) begin
            bm_r <= data_in;
        end
    end

    // A BRATE write restarts the rate count and wins over a same-cycle tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            br_r  <= 8'h0F;
            rcnt  <= 8'h00;
            phase <= 1'b0;
        end else if (br_wr) begin
            br_r <= data_in;
            rcnt <= 8'h00;
        end else if (tick) begin
            if (rcnt == br_r) begin
                rcnt  <= 8'h00;
                phase <= ~phase;
            end else begin
                rcnt <= rcnt + 8'd1;
            end
        end
    end

    assign lit       = led_r & ~(bm_r & {8{phase}});
    assign bm_rd     = bm_r;
    assign br_rd     = br_r;
    assign status_rd = {7'b0, phase};
`else
    assign lit       = led_r;
    assign bm_rd     = 8'h00;
    assign br_rd     = 8'h00;
    assign status_rd = 8'h00;
`endif

    always_comb begin
        data_out = 8'h00;
        if (sel) begin
            case (offset)
                OFF_LED,
                OFF_SET,
                OFF_CLR,
                OFF_TGL:    data_out = led_r;
                OFF_BMASK:  data_out = bm_rd;
                OFF_BRATE:  data_out = br_rd;
                OFF_STATUS: data_out = status_rd;
                OFF_ID:     data_out = ID_VALUE;
                default:    data_out = 8'h00;
            endcase
        end
    end

    // Pins follow the lit vector one clock later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            leds <= LEDS_IDLE;
        end else if (ACTIVE_LOW != 0) begin
            leds <= ~lit;
        end else begin
            leds <= lit;
        end
    end

endmodule

// File: tb/tb_led_panel_mmio.sv
// tb_led_panel_mmio: directed self-checking bench for led_panel_mmio.
// Blink scenarios are built when LEDPANEL_BLINK_EN is defined.
module tb_led_panel_mmio;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [18:0] address = 19'h0F100;
    logic        write_en = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        sel;
    logic [7:0]  leds;

    int tests = 0;
    int fails = 0;

    led_panel_mmio #(
        .BASE_ADDR (19'h0F100),
        .ACTIVE_LOW(1),
        .PRESCALE  (4)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .address (address),
        .write_en(write_en),
        .data_in (data_in),
        .data_out(data_out),
        .sel     (sel),
        .leds    (leds)
    );

    always #5 clock = ~clock;

    task automatic bus_write(input logic [18:0] a, input logic [7:0] d);
        @(negedge clock);
        address  = a;
        data_in  = d;
        write_en = 1'b1;
        @(negedge clock);
        write_en = 1'b0;
    endtask

    task automatic bus_read(input logic [18:0] a, output logic [7:0] d);
        address = a;
        #1;
        d = data_out;
    endtask

    task automatic test_reset;
        logic [7:0] d;
        logic [7:0] exp_br;
        @(negedge clock);
        tests++;
        if (leds !== 8'hFF) begin
            fails++;
            $display("FAIL reset_leds: got %h want ff", leds);
        end
        @(negedge clock);
        reset = 1'b0;
        bus_read(19'h0F107, d);
        tests++;
        if (d !== 8'h4C) begin
            fails++;
            $display("FAIL reset_id: got %h want 4c", d);
        end
`ifdef LEDPANEL_BLINK_EN
        exp_br = 8'h0F;
`else
        exp_br = 8'h00;
`endif
        bus_read(19'h0F105, d);
        tests++;
        if (d !== exp_br) begin
            fails++;
            $display("FAIL reset_brate: got %h want %h", d, exp_br);
        end
        bus_read(19'h0F100, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL reset_led_r: got %h want 00", d);
        end
    endtask

    task automatic test_regs;
        logic [7:0] d;
        bus_write(19'h0F100, 8'hA5);
        bus_read(19'h0F100, d);
        tests++;
        if (d !== 8'hA5) begin
            fails++;
            $display("FAIL led_write: got %h want a5", d);
        end
        @(negedge clock);
        tests++;
        if (leds !== 8'h5A) begin
            fails++;
            $display("FAIL led_pins: got %h want 5a", leds);
        end
        bus_write(19'h0F101, 8'h0F);
        bus_read(19'h0F101, d);
        tests++;
        if (d !== 8'hAF) begin
            fails++;
            $display("FAIL set_alias: got %h want af", d);
        end
        bus_write(19'h0F102, 8'h21);
        bus_read(19'h0F102, d);
        tests++;
        if (d !== 8'h8E) begin
            fails++;
            $display("FAIL clr_alias: got %h want 8e", d);
        end
        bus_write(19'h0F103, 8'hFF);
        bus_read(19'h0F103, d);
        tests++;
        if (d !== 8'h71) begin
            fails++;
            $display("FAIL tgl_alias: got %h want 71", d);
        end
        @(negedge clock);
        tests++;
        if (leds !== 8'h8E) begin
            fails++;
            $display("FAIL tgl_pins: got %h want 8e", leds);
        end
        bus_write(19'h0F107, 8'h00);
        bus_read(19'h0F107, d);
        tests++;
        if (d !== 8'h4C) begin
            fails++;
            $display("FAIL id_readonly: got %h want 4c", d);
        end
    endtask

    task automatic test_decode;
        logic [7:0] d;
        @(negedge clock);
        address  = 19'h0F108;
        data_in  = 8'hFF;
        write_en = 1'b1;
        #1;
        tests++;
        if (sel !== 1'b0 || data_out !== 8'h00) begin
            fails++;
            $display("FAIL decode_above: sel %b data %h want 0 00", sel, data_out);
        end
        @(negedge clock);
        address = 19'h1F100;
        #1;
        tests++;
        if (sel !== 1'b0 || data_out !== 8'h00) begin
            fails++;
            $display("FAIL decode_alias: sel %b data %h want 0 00", sel, data_out);
        end
        @(negedge clock);
        address = 19'h0F0FF;
        #1;
        tests++;
        if (sel !== 1'b0 || data_out !== 8'h00) begin
            fails++;
            $display("FAIL decode_below: sel %b data %h want 0 00", sel, data_out);
        end
        @(negedge clock);
        write_en = 1'b0;
        bus_read(19'h0F100, d);
        tests++;
        if (sel !== 1'b1 || d !== 8'h71) begin
            fails++;
            $display("FAIL decode_unchanged: sel %b data %h want 1 71", sel, d);
        end
    endtask

`ifdef LEDPANEL_BLINK_EN
    task automatic test_blink;
        logic prev;
        logic ph0;
        logic cur;
        logic exp;
        logic prv;
        bit   found;
        bus_write(19'h0F100, 8'hFF);
        bus_write(19'h0F104, 8'h01);
        bus_write(19'h0F105, 8'h00);
        address = 19'h0F106;
        #1;
        prev  = data_out[0];
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            #1;
            if (data_out[0] !== prev) found = 1'b1;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL blink_start: no phase toggle within 20 cycles");
            return;
        end
        ph0 = data_out[0];
        // Rate 0: phase flips on every 4-cycle tick; pins lag phase by a clock.
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            #1;
            exp = ph0 ^ (k >= 4) ^ (k >= 8);
            prv = ph0 ^ ((k - 1) >= 4) ^ ((k - 1) >= 8);
            tests++;
            if (data_out[0] !== exp) begin
                fails++;
                $display("FAIL blink_rate0 k=%0d: phase %b want %b", k, data_out[0], exp);
            end
            tests++;
            if (leds !== {7'b0, prv}) begin
                fails++;
                $display("FAIL blink_pins k=%0d: leds %h want %h", k, leds, {7'b0, prv});
            end
        end
        cur = ph0;
        repeat (3) @(negedge clock);
        address  = 19'h0F105;
        data_in  = 8'h00;
        write_en = 1'b1;
        @(negedge clock);
        write_en = 1'b0;
        address  = 19'h0F106;
        #1;
        tests++;
        if (data_out[0] !== cur) begin
            fails++;
            $display("FAIL brate_tick_collide: phase %b want %b", data_out[0], cur);
        end
        repeat (3) @(negedge clock);
        #1;
        tests++;
        if (data_out[0] !== cur) begin
            fails++;
            $display("FAIL brate_collide_hold: phase %b want %b", data_out[0], cur);
        end
        @(negedge clock);
        #1;
        tests++;
        if (data_out[0] !== ~cur) begin
            fails++;
            $display("FAIL brate_collide_next: phase %b want %b", data_out[0], ~cur);
        end
        cur = ~cur;
        @(negedge clock);
        address  = 19'h0F105;
        data_in  = 8'h02;
        write_en = 1'b1;
        @(negedge clock);
        write_en = 1'b0;
        address  = 19'h0F106;
        // Rate 2 restarted two cycles after a tick: flips at relative 12 and 24.
        for (int k = 3; k <= 24; k++) begin
            @(negedge clock);
            #1;
            exp = cur ^ (k >= 12) ^ (k >= 24);
            tests++;
            if (data_out[0] !== exp) begin
                fails++;
                $display("FAIL blink_rate2 k=%0d: phase %b want %b", k, data_out[0], exp);
            end
        end
    endtask
`else
    task automatic test_no_blink;
        logic [7:0] d;
        bus_write(19'h0F104, 8'h33);
        bus_read(19'h0F104, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL nb_bmask: got %h want 00", d);
        end
        bus_write(19'h0F105, 8'h07);
        bus_read(19'h0F105, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL nb_brate: got %h want 00", d);
        end
        bus_read(19'h0F106, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL nb_status: got %h want 00", d);
        end
        bus_write(19'h0F104, 8'hFF);
        bus_write(19'h0F100, 8'h3C);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            tests++;
            if (leds !== 8'hC3) begin
                fails++;
                $display("FAIL nb_pins k=%0d: leds %h want c3", k, leds);
            end
        end
    endtask
`endif

    task automatic test_reset_mid;
        logic [7:0] d;
        address = 19'h0F100;
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        tests++;
        if (leds !== 8'hFF) begin
            fails++;
            $display("FAIL midreset_leds: got %h want ff", leds);
        end
        tests++;
        if (data_out !== 8'h00) begin
            fails++;
            $display("FAIL midreset_led_r: got %h want 00", data_out);
        end
        @(negedge clock);
        reset = 1'b0;
`ifdef LEDPANEL_BLINK_EN
        bus_read(19'h0F105, d);
        tests++;
        if (d !== 8'h0F) begin
            fails++;
            $display("FAIL midreset_brate: got %h want 0f", d);
        end
        bus_read(19'h0F104, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL midreset_bmask: got %h want 00", d);
        end
`else
        bus_read(19'h0F107, d);
        tests++;
        if (d !== 8'h4C) begin
            fails++;
            $display("FAIL midreset_id: got %h want 4c", d);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_regs();
        test_decode();
`ifdef LEDPANEL_BLINK_EN
        test_blink();
`else
        test_no_blink();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
